// File: rtl/flash_reader_pkg.sv
// rtl/flash_reader_pkg.sv - shared types, defaults and helpers for the flash burst reader
package flash_reader_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DATA,
    ST_DRAIN,
    ST_DONE
  } flash_rd_state_t;

  function automatic logic [31:0] burst_len(input logic [31:0] remaining, input logic [31:0] max);
    return (remaining < max) ? remaining : max;
  endfunction

endpackage

// File: rtl/flash_rd_fifo.sv
// rtl/flash_rd_fifo.sv - synchronous first-word-fall-through FIFO for returned flash beats
module flash_rd_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader's admission rule should make this unreachable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/flash_burst_reader.sv
// rtl/flash_burst_reader.sv - Avalon-MM burst reader from flash into a valid/ready stream
module flash_burst_reader
  import flash_reader_pkg::*;
#(
  parameter int ADDR_W     = FLASH_ADDR_W,
  parameter int DATA_W     = FLASH_DATA_W,
  parameter int CNT_W      = 16,
  parameter int BURST_MAX  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic [CNT_W-1:0]             word_count,
  output logic                         busy,
  output logic                         done,
  output logic                         flash_read,
  output logic [ADDR_W-1:0]            flash_address,
  output logic [$clog2(BURST_MAX):0]   flash_burstcount,
  input  logic                         flash_waitrequest,
  input  logic                         flash_readdatavalid,
  input  logic [DATA_W-1:0]            flash_readdata,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int BC_W = $clog2(BURST_MAX) + 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  flash_rd_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [BC_W-1:0]   bc;
  logic              rd;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [31:0]       free_words;
  logic              space_ok;

  assign bc         = BC_W'(burst_len(32'(rem_q), 32'(BURST_MAX)));
  assign free_words = 32'(FIFO_DEPTH) - 32'(fifo_count);
  // No beats are pushed while in REQ, so once raised the request cannot lose its admission.
  assign space_ok   = (free_words >= 32'(BURST_MAX));
  assign push       = (state_q == ST_WAIT_DATA) && flash_readdatavalid;
  assign pop        = out_valid && out_ready;
  assign out_valid  = !fifo_empty;

  flash_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (flash_readdata),
    .dout  (out_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    rd      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = word_count;
          state_d = (word_count == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (space_ok) begin
          rd = 1'b1;
          if (!flash_waitrequest) begin
            addr_d  = addr_q + ADDR_W'(bc);
            rem_d   = rem_q - CNT_W'(bc);
            beat_d  = bc;
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (flash_readdatavalid) begin
          beat_d = beat_q - 1'b1;
          if (beat_q == BC_W'(1)) begin
            state_d = (rem_q != '0) ? ST_REQ : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the last word is taken so done follows the final handshake directly.
        if (fifo_empty || ((fifo_count == CW'(1)) && pop)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
    end
  end

  assign flash_read       = rd;
  assign flash_address    = rd ? addr_q : '0;
  assign flash_burstcount = rd ? bc : '0;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);

endmodule
